// File: rtl/bus_arbiter4_32_if.sv
// Signal bundle between the four requesters, the slave port and the round-robin arbiter.
// The arbiter takes the master view because it drives the shared bus toward the slave.
interface bus_arbiter4_32_if;
   logic [3:0]  Req;
   logic [31:0] Data_0;
   logic [31:0] Data_1;
   logic [31:0] Data_2;
   logic [31:0] Data_3;
   logic        Ack;
   logic [3:0]  Grant;
   logic [1:0]  Select;
   logic [31:0] Bus_out;
   logic        Bus_valid;
   logic        Timeout_err;

   modport master (
      input  Req, Data_0, Data_1, Data_2, Data_3, Ack,
      output Grant, Select, Bus_out, Bus_valid, Timeout_err
   );

   modport slave (
      output Req, Data_0, Data_1, Data_2, Data_3, Ack,
      input  Grant, Select, Bus_out, Bus_valid, Timeout_err
   );
endinterface

// File: rtl/bus_arbiter4_32.sv
// Four-way round-robin arbiter for a shared 32-bit slave port.
// A grant stays locked until Ack arrives or TIMEOUT cycles pass, then a one-cycle turnaround follows.
module bus_arbiter4_32 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   bus_arbiter4_32_if.master    bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  select_q, select_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [3:0]  req_rot;
   logic [1:0]  win_off;
   logic [1:0]  winner;
   logic [31:0] data [4];

   // Rotate requests so bit 0 is the requester currently holding top priority.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = bus.Req[2'(ptr_q + 2'(gi))];
   end

   always_comb begin
      win_off = 2'd3;
      if (req_rot[0]) begin
         win_off = 2'd0;
      end else if (req_rot[1]) begin
         win_off = 2'd1;
      end else if (req_rot[2]) begin
         win_off = 2'd2;
      end
   end

   assign winner = ptr_q + win_off;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      select_d = select_q;
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.Req) begin
               state_d  = BUSY;
               select_d = winner;
               grant_d  = 4'(4'b0001 << winner);
               valid_d  = 1'b1;
               cnt_d    = 8'd0;
            end
         end
         BUSY: begin
            // Ack outranks a coinciding timeout, so only an unacknowledged release flags an error.
            if (bus.Ack || (cnt_q == CNT_LAST)) begin
               state_d = TURN;
               ptr_d   = select_q + 2'd1;
               grant_d = 4'b0000;
               valid_d = 1'b0;
               err_d   = ~bus.Ack;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 4'b0000;
         select_q <= 2'd0;
         ptr_q    <= 2'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         select_q <= select_d;
         ptr_q    <= ptr_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data[0] = bus.Data_0;
   assign data[1] = bus.Data_1;
   assign data[2] = bus.Data_2;
   assign data[3] = bus.Data_3;

   // Payload follows live requester data but only while a transaction is on the bus.
   assign bus.Bus_out     = valid_q ? data[select_q] : 32'h0;
   assign bus.Grant       = grant_q;
   assign bus.Select      = select_q;
   assign bus.Bus_valid   = valid_q;
   assign bus.Timeout_err = err_q;
endmodule

// File: tb/tb_bus_arbiter4_32.sv
// Directed bench for the round-robin bus arbiter: a transaction-level reference model is
// checked against the DUT every cycle, plus literal expectations from the test scenarios.
module tb_bus_arbiter4_32;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   bus_arbiter4_32_if bus ();

   bus_arbiter4_32 #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) begin
         if (g[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] data_of(input int i);
      case (i)
         0:       return bus.Data_0;
         1:       return bus.Data_1;
         2:       return bus.Data_2;
         default: return bus.Data_3;
      endcase
   endfunction

   // Reference model: who owns the bus, how long they have held it, and whose turn is next.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int m_sel   = 0;
   bit m_turn  = 1'b0;
   bit m_err   = 1'b0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_turn = 1'b0; m_err = 1'b0;
      end else if (m_owner >= 0) begin
         if (bus.Ack || (m_held + 1 == TO)) begin
            m_err   = (bus.Ack == 1'b0);
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_turn  = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_turn) begin
         m_turn = 1'b0;
         m_err  = 1'b0;
      end else if (bus.Req != 4'b0000) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.Req[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               break;
            end
         end
         m_sel  = m_owner;
         m_held = 0;
      end
   end

   initial begin : cmp_proc
      logic [3:0]  eg;
      logic [31:0] eb;
      forever begin
         @(negedge clk);
         eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
         eb = (m_owner >= 0) ? data_of(m_owner) : 32'h0;
         chk("Grant", 32'(bus.Grant), 32'(eg));
         chk("Select", 32'(bus.Select), 32'(m_sel));
         chk("Bus_valid", 32'(bus.Bus_valid), 32'(m_owner >= 0));
         chk("Bus_out", bus.Bus_out, eb);
         chk("Timeout_err", 32'(bus.Timeout_err), 32'(m_err));
         chk("Grant_onehot", 32'($countones(bus.Grant) <= 1), 32'd1);
      end
   end

   // Transaction monitor: one log entry and one printed line per completed bus tenure.
   int cyc = 0;
   int log_who[$];
   int log_len[$];
   int log_start[$];
   int err_pulses = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : mon_proc
      logic prev_v;
      int cur_len, cur_who, cur_start;
      prev_v = 1'b0; cur_len = 0; cur_who = -1; cur_start = 0;
      forever begin
         @(negedge clk);
         if (bus.Timeout_err) err_pulses++;
         if (bus.Bus_valid) begin
            if (!prev_v) begin
               cur_len   = 0;
               cur_start = cyc;
               cur_who   = idx_of(bus.Grant);
            end
            cur_len++;
         end else if (prev_v) begin
            log_who.push_back(cur_who);
            log_len.push_back(cur_len);
            log_start.push_back(cur_start);
            $display("txn: requester %0d held bus %0d cycles from cycle %0d", cur_who, cur_len, cur_start);
         end
         prev_v = bus.Bus_valid;
      end
   end

   task automatic wait_grant(output int who);
      who = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.Grant != 4'b0000) begin
            who = idx_of(bus.Grant);
            break;
         end
      end
      chk("grant_seen", 32'(who >= 0), 32'd1);
   endtask

   // Waits for a grant, keeps Ack low for 'hold' further cycles, then acks once.
   task automatic run_txn(input int hold, output int who);
      wait_grant(who);
      if (who < 0) return;
      repeat (hold) @(negedge clk);
      bus.Ack = 1'b1;
      @(posedge clk);
      #1 bus.Ack = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int w;
      int errs0;
      int t2_exp[5];
      t2_exp = '{0, 1, 2, 3, 0};

      bus.Req = 4'b0000; bus.Ack = 1'b0;
      bus.Data_0 = 32'h1000_0000; bus.Data_1 = 32'h1111_1111;
      bus.Data_2 = 32'h2222_2222; bus.Data_3 = 32'h3333_3333;
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_Grant", 32'(bus.Grant), 32'd0);
      chk("rst_Select", 32'(bus.Select), 32'd0);
      chk("rst_Bus_valid", 32'(bus.Bus_valid), 32'd0);
      chk("rst_Bus_out", bus.Bus_out, 32'h0);
      chk("rst_Timeout_err", 32'(bus.Timeout_err), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // Single request from 2, acked after two extra cycles.
      bus.Data_2 = 32'hDEAD_BEEF;
      bus.Req    = 4'b0100;
      wait_grant(w);
      chk("t1_who", 32'(w), 32'd2);
      chk("t1_Grant", 32'(bus.Grant), 32'h4);
      chk("t1_Select", 32'(bus.Select), 32'd2);
      chk("t1_Bus_out", bus.Bus_out, 32'hDEAD_BEEF);
      bus.Req = 4'b1001;
      repeat (2) @(negedge clk);
      bus.Ack = 1'b1;
      @(posedge clk);
      #1 bus.Ack = 1'b0;
      @(negedge clk);
      chk("t1_Grant_released", 32'(bus.Grant), 32'd0);
      @(negedge clk);
      chk("t1_len", 32'(log_len[$]), 32'd3);

      // Pointer now sits at 3: requester 3 beats 0, then 0 follows.
      run_txn(0, w);
      chk("t3_first", 32'(w), 32'd3);
      run_txn(0, w);
      chk("t3_second", 32'(w), 32'd0);
      bus.Req = 4'b0000;
      settle();

      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      log_who.delete(); log_len.delete(); log_start.delete();

      // All four requesting, immediate Ack: strict rotation with 3-cycle spacing.
      bus.Req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         run_txn(0, w);
         chk("t2_order", 32'(w), 32'(t2_exp[i]));
      end
      bus.Req = 4'b0000;
      settle();
      chk("t2_count", 32'(log_len.size()), 32'd5);
      for (int i = 1; i < 5; i++) begin
         chk("t2_spacing", 32'(log_start[i] - log_start[i-1]), 32'd3);
         chk("t2_len", 32'(log_len[i]), 32'd1);
      end

      // Timeout on requester 1; the next grant must go to requester 2.
      errs0   = err_pulses;
      bus.Req = 4'b0010;
      wait_grant(w);
      chk("t4_who", 32'(w), 32'd1);
      bus.Req = 4'b0110;
      repeat (TO) @(negedge clk);
      chk("t4_err_high", 32'(bus.Timeout_err), 32'd1);
      chk("t4_valid_low", 32'(bus.Bus_valid), 32'd0);
      @(negedge clk);
      chk("t4_err_low", 32'(bus.Timeout_err), 32'd0);
      chk("t4_len", 32'(log_len[$]), 32'(TO));
      chk("t4_pulses", 32'(err_pulses - errs0), 32'd1);
      wait_grant(w);
      chk("t4_next", 32'(w), 32'd2);
      bus.Req = 4'b0000;
      bus.Ack = 1'b1;
      @(posedge clk);
      #1 bus.Ack = 1'b0;
      settle();

      // Owner drops Req immediately; grant must hold until the late Ack.
      bus.Req = 4'b0001;
      wait_grant(w);
      chk("t5_who", 32'(w), 32'd0);
      bus.Req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_held", 32'(bus.Grant), 32'h1);
      end
      bus.Ack = 1'b1;
      @(posedge clk);
      #1 bus.Ack = 1'b0;
      settle();
      chk("t5_len", 32'(log_len[$]), 32'd6);

      // Ack lands in the final allowed cycle: release without an error pulse.
      errs0   = err_pulses;
      bus.Req = 4'b0010;
      wait_grant(w);
      chk("t6_who", 32'(w), 32'd1);
      bus.Req = 4'b0000;
      repeat (TO - 1) @(negedge clk);
      bus.Ack = 1'b1;
      @(posedge clk);
      #1 bus.Ack = 1'b0;
      settle();
      chk("t6_len", 32'(log_len[$]), 32'(TO));
      chk("t6_no_err", 32'(err_pulses - errs0), 32'd0);

      // Ack while idle must be ignored.
      bus.Ack = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_idle_ack", 32'(bus.Bus_valid), 32'd0);
      bus.Ack = 1'b0;

      // Asynchronous reset in the middle of a tenure, then arbitration restarts at 0.
      bus.Req = 4'b1000;
      wait_grant(w);
      chk("t7_who", 32'(w), 32'd3);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t7_Grant", 32'(bus.Grant), 32'd0);
      chk("t7_Bus_valid", 32'(bus.Bus_valid), 32'd0);
      chk("t7_Bus_out", bus.Bus_out, 32'h0);
      chk("t7_Select", 32'(bus.Select), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      bus.Req = 4'b1111;
      run_txn(0, w);
      chk("t7_restart", 32'(w), 32'd0);
      bus.Req = 4'b0000;
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bus_arbiter4_32.md
# bus_arbiter4_32

Round-robin arbiter and sequencer for a shared 32-bit bus with four requesters. It owns the 2-bit select of the 4:1 32-bit bus multiplexer and locks a grant until the downstream slave acknowledges or a timeout fires. It sits between the pipeline's memory-side requesters (instruction fetch, data load/store, DMA, debug) and a single slave port.

## Interface
- TIMEOUT, 16: cycles a grant may stay in BUSY without Ack before abort; legal 2..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Req  input  4  per-requester request; bit i belongs to requester i.
- Data_0, Data_1, Data_2, Data_3  input  32 each  requester payloads (address/write data).
- Ack  input  1  slave completion strobe; sampled only in BUSY.
- Grant  output  4  one-hot grant; all zero when no owner.
- Select  output  2  registered mux select (index of owner).
- Bus_out  output  32  payload of owner; 32'h0 when Bus_valid=0.
- Bus_valid  output  1  high while a transaction is driven to the slave.
- Timeout_err  output  1  one-cycle pulse when a transaction is aborted.

## Operation
- States: IDLE, BUSY, TURN (one-cycle turnaround).
- Reset (async, any state, mid-transaction included): state=IDLE, Grant=4'b0000, Select=2'b00, Bus_valid=0, Bus_out=0, Timeout_err=0, priority pointer Ptr=2'd0, timeout counter=0.
- IDLE: if Req!=0, winner = first set bit searching Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4). Next edge: Select=winner, Grant=1<<winner, Bus_valid=1, counter=0, state=BUSY. If Req==0, stay IDLE.
- BUSY: Bus_out = Data_Select (combinational from registered Select). Grant locked; changes on Req ignored, including owner dropping its Req.
  - Ack=1: next edge Ptr=Select+1 (wraps 3->0), Grant=0, Bus_valid=0, state=TURN.
  - Ack=0 and counter==TIMEOUT-1: next edge same release actions as Ack, plus Timeout_err=1 for exactly one cycle.
  - Otherwise counter increments.
  - Ack and timeout in same cycle: Ack wins, no Timeout_err.
- TURN: outputs idle, Timeout_err cleared; next edge state=IDLE. Select holds last value.
- Ptr advances only on release; an aborted owner also loses priority.
- Counter width 8 bits; never exceeds TIMEOUT-1.

## Timing
- Request-to-grant latency: 1 cycle (Req seen in IDLE at edge N, Grant/Bus_valid high after edge N).
- Minimum transaction: Ack in first BUSY cycle -> Bus_valid high exactly 1 cycle.
- Grant-to-grant spacing: minimum 3 cycles (BUSY, TURN, IDLE); back-to-back grants never overlap, Grant is never multi-hot.
- Timeout: Bus_valid high for exactly TIMEOUT cycles; Timeout_err asserted in the first TURN cycle.
- Ack outside BUSY ignored; Req sampled only in IDLE.
- All outputs except Bus_out are registered; Bus_out is a combinational mux of registered Select and live Data_i, gated by Bus_valid.

## Test plan
- Reset then Req=4'b0100, Data_2=32'hDEAD_BEEF, Ack after 2 cycles -> Grant=4'b0100, Select=2, Bus_out=32'hDEADBEEF for 3 cycles, then Grant=0, Ptr=3.
- Req=4'b1111 held, Ack every BUSY cycle -> grants in order 0,1,2,3,0 with 3-cycle spacing; Grant always one-hot.
- Req=4'b1001 with Ptr=3 after prior grant to 2 -> requester 3 granted first, then requester 0.
- TIMEOUT=4, Req=4'b0010, Ack never -> Bus_valid high 4 cycles, Timeout_err single pulse, next grant skips to requester 2 if requesting.
- Owner drops Req mid-BUSY, Ack arrives 5 cycles later -> grant held until Ack, no early release.
- reset asserted mid-BUSY between edges -> Grant, Bus_valid, Bus_out go to 0 immediately; after release, arbitration restarts from requester 0.
